// File: rtl/lfsr_pkg.sv
// Definitions shared by the 8-bit LFSR generator and checker: width, tap mask,
// step function and checker state encoding.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps q[4], q[3], q[2], q[0]; the feedback bit enters at the MSB.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } lfsr_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Byte stream in, lock/error status out; master drives the stream, slave is the checker.
// No backpressure: every valid beat is consumed.
interface lfsr_checker_if #(
    parameter int CNT_W = 8
);
    import lfsr_pkg::*;

    logic [LFSR_W-1:0] i_data;
    logic              i_valid;
    logic              i_clr;
    logic              o_locked;
    logic              o_err;
    logic [CNT_W-1:0]  o_err_cnt;
    logic [LFSR_W-1:0] o_expect;

    modport master (
        output i_data, i_valid, i_clr,
        input  o_locked, o_err, o_err_cnt, o_expect
    );

    modport slave (
        input  i_data, i_valid, i_clr,
        output o_locked, o_err, o_err_cnt, o_expect
    );

endinterface

// File: rtl/lfsr_step.sv
// Combinational one-step advance of the 8-bit LFSR; zero latency, no flow control.
// Instantiated by both generator and checker so their sequences cannot diverge.
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] cur,
    output logic [LFSR_W-1:0] nxt
);

    assign nxt = lfsr_next(cur);

endmodule

// File: rtl/seg_hex.sv
// Two-digit hex decoder for a seven-segment pair, segments {dp,g,f,e,d,c,b,a} active high.
// Purely combinational; no flow control.
module seg_hex (
    input  logic [7:0] value,
    output logic [7:0] seg_1,
    output logic [7:0] seg_0
);

    function automatic logic [7:0] digit(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    assign seg_1 = digit(value[7:4]);
    assign seg_0 = digit(value[3:0]);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR byte checker: HUNT -> VERIFY -> LOCK, flags and counts mismatches.
// Outputs update one cycle after the deciding beat; no backpressure. LFSR_CHK_SEG_EN adds the hex display.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_MISS = 3,
    parameter int CNT_W       = 8
)(
    input  logic              clk,
    input  logic              rst,
    lfsr_checker_if.slave     bus
`ifdef LFSR_CHK_SEG_EN
    ,
    output logic [7:0]        o_seg_1,
    output logic [7:0]        o_seg_0
`endif
);

    lfsr_state_e       state_q, state_n;
    logic [3:0]        run_q, run_n, run_inc;
    logic [3:0]        miss_q, miss_n, miss_inc;
    logic [LFSR_W-1:0] exp_q, exp_n;
    logic              err_n, err_q;
    logic              cnt_inc;
    logic [CNT_W-1:0]  cnt_q;
    logic              locked_q;
    logic [LFSR_W-1:0] step_data, step_exp;
    logic              match;

    lfsr_step u_step_data (.cur(bus.i_data), .nxt(step_data));
    lfsr_step u_step_exp  (.cur(exp_q),      .nxt(step_exp));

    assign match    = (bus.i_data == exp_q);
    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    always_comb begin
        state_n = state_q;
        run_n   = run_q;
        miss_n  = miss_q;
        exp_n   = exp_q;
        err_n   = 1'b0;
        cnt_inc = 1'b0;
        if (bus.i_valid) begin
            case (state_q)
                HUNT: begin
                    // All-zero is the LFSR lock-up value and can never seed a valid sequence.
                    if (bus.i_data != '0) begin
                        exp_n   = step_data;
                        run_n   = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        run_n = run_inc;
                        exp_n = step_exp;
                        if (run_inc == 4'(LOCK_CNT)) begin
                            state_n = LOCK;
                            miss_n  = '0;
                        end
                    end else if (bus.i_data == '0) begin
                        run_n   = '0;
                        state_n = HUNT;
                    end else begin
                        exp_n = step_data;
                        run_n = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: keep predicting from our own state so a corrupt byte never reseeds.
                    exp_n = step_exp;
                    if (match) begin
                        miss_n = '0;
                    end else begin
                        err_n   = 1'b1;
                        cnt_inc = 1'b1;
                        if (miss_inc == 4'(UNLOCK_MISS)) begin
                            miss_n  = '0;
                            state_n = HUNT;
                        end else begin
                            miss_n = miss_inc;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    run_n   = '0;
                    miss_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            run_q    <= '0;
            miss_q   <= '0;
            exp_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            run_q    <= run_n;
            miss_q   <= miss_n;
            exp_q    <= exp_n;
            err_q    <= err_n;
            locked_q <= (state_n == LOCK);
            if (bus.i_clr)
                cnt_q <= '0;
            else if (cnt_inc && !(&cnt_q))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.o_locked  = locked_q;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = cnt_q;
    assign bus.o_expect  = exp_q;

`ifdef LFSR_CHK_SEG_EN
    logic [7:0] seg_val;
    assign seg_val = 8'(cnt_q);

    seg_hex u_seg_hex (
        .value (seg_val),
        .seg_1 (o_seg_1),
        .seg_0 (o_seg_0)
    );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: vector table plus hand-written saturation and reset sequences.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_checker_if #(.CNT_W(8)) bus ();

`ifdef LFSR_CHK_SEG_EN
    logic [7:0] seg_1, seg_0;
`endif

    lfsr_checker #(.LOCK_CNT(4), .UNLOCK_MISS(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef LFSR_CHK_SEG_EN
        ,
        .o_seg_1 (seg_1),
        .o_seg_0 (seg_0)
`endif
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       lk;
        logic       er;
        logic [7:0] cnt;
        logic [7:0] ex;
    } vec_t;

    vec_t tbl [20];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic er,
                           input logic [7:0] cnt, input logic [7:0] ex);
        chk({tag, ".locked"}, {7'd0, bus.o_locked}, {7'd0, lk});
        chk({tag, ".err"},    {7'd0, bus.o_err},    {7'd0, er});
        chk({tag, ".cnt"},    bus.o_err_cnt,        cnt);
        chk({tag, ".expect"}, bus.o_expect,         ex);
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic beat(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_seq();
        beat(1'b1, 8'h01, 1'b0);
        beat(1'b1, 8'h80, 1'b0);
        beat(1'b1, 8'h40, 1'b0);
        beat(1'b1, 8'h20, 1'b0);
        beat(1'b1, 8'h10, 1'b0);
    endtask

    initial begin
        int model_cnt;
        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80};
        tbl[1]  = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40};
        tbl[2]  = '{1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40};
        tbl[3]  = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20};
        tbl[4]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10};
        tbl[5]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h88};
        tbl[6]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h01, 8'hC4};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 8'hC4};
        tbl[8]  = '{1'b1, 8'hC4, 1'b0, 1'b1, 1'b0, 8'h01, 8'hE2};
        tbl[9]  = '{1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 8'h01, 8'h71};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h71};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 8'h38};
        tbl[12] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h02, 8'h1C};
        tbl[13] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h03, 8'h8E};
        tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 8'h8E};
        tbl[15] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 8'h8E};
        tbl[16] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h03, 8'h80};
        tbl[17] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h03, 8'h88};
        tbl[18] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 8'h03, 8'hC4};
        tbl[19] = '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 8'h03, 8'hE2};

        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_clr   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            beat(tbl[i].v, tbl[i].d, tbl[i].c);
            chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].cnt, tbl[i].ex);
        end

        // Zero byte in VERIFY returns to HUNT; then saturate the counter over repeated relocks.
        beat(1'b1, 8'h00, 1'b0);
        beat(1'b0, 8'h00, 1'b1);
        chk("sat.clr", bus.o_err_cnt, 8'h00);
        model_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            lock_seq();
            chk($sformatf("sat.lock%0d", k), {7'd0, bus.o_locked}, 8'h01);
            repeat (3) beat(1'b1, 8'h00, 1'b0);
            model_cnt = (model_cnt + 3 > 255) ? 255 : model_cnt + 3;
            chk($sformatf("sat.cnt%0d", k), bus.o_err_cnt, 8'(model_cnt));
            chk($sformatf("sat.unlock%0d", k), {7'd0, bus.o_locked}, 8'h00);
        end

        // Clear and a counted error in the same beat: clear wins, pulse still fires.
        lock_seq();
        chk("clr.pre_cnt", bus.o_err_cnt, 8'hFF);
        beat(1'b1, 8'h00, 1'b1);
        chk_all("clr_err", 1'b1, 1'b1, 8'h00, 8'hC4);

        // Reset mid-LOCK with a wrong byte on the bus: everything discarded.
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h00;
        bus.i_clr   = 1'b0;
        @(posedge clk);
        #1;
        chk_all("midrst", 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        beat(1'b1, 8'h01, 1'b0);
        beat(1'b1, 8'h80, 1'b0);
        beat(1'b1, 8'h40, 1'b0);
        beat(1'b1, 8'h20, 1'b0);
        chk_all("relock4", 1'b0, 1'b0, 8'h00, 8'h10);
        beat(1'b1, 8'h10, 1'b0);
        chk_all("relock5", 1'b1, 1'b0, 8'h00, 8'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
